// File: rtl/traffic_light_ctrl.sv
// rtl/traffic_light_ctrl.sv - two-road traffic-light sequencer with pedestrian phase
//
// Purpose: steps north-south / east-west lights through green, yellow and
// all-red phases, with an optional pedestrian WALK phase after ALLRED2. The
// phase timers advance on a one-cycle tick. The tick comes from a synchronised
// rising edge of the external 1 Hz wave. That wave is sampled as data and is
// never used as a clock.
//
// Ports:
//   clk_100MHz   in   system clock
//   reset        in   asynchronous active-high reset
//   clk_1Hz      in   asynchronous 1 Hz square wave
//   ped_req      in   asynchronous pedestrian button (level or pulse)
//   ns_light     out  {red, yellow, green} north-south, one-hot
//   ew_light     out  {red, yellow, green} east-west, one-hot
//   walk         out  pedestrian walk lamp
//   seconds_left out  ticks remaining in the current phase
//   tick         out  one-cycle strobe per 1 Hz rising edge
module traffic_light_ctrl #(
  parameter int GREEN_S  = 10,
  parameter int YELLOW_S = 3,
  parameter int ALLRED_S = 1,
  parameter int WALK_S   = 5
) (
  input  logic       clk_100MHz,
  input  logic       reset,
  input  logic       clk_1Hz,
  input  logic       ped_req,
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic       walk,
  output logic [5:0] seconds_left,
  output logic       tick
);

  // A zero duration would leave the timer at 0, so it is raised to 1.
  localparam logic [5:0] L_GREEN  = (GREEN_S  < 1) ? 6'd1 : 6'(GREEN_S);
  localparam logic [5:0] L_YELLOW = (YELLOW_S < 1) ? 6'd1 : 6'(YELLOW_S);
  localparam logic [5:0] L_ALLRED = (ALLRED_S < 1) ? 6'd1 : 6'(ALLRED_S);
  localparam logic [5:0] L_WALK   = (WALK_S   < 1) ? 6'd1 : 6'(WALK_S);

  typedef enum logic [2:0] {
    S_NS_GREEN  = 3'd0,
    S_NS_YELLOW = 3'd1,
    S_ALLRED1   = 3'd2,
    S_EW_GREEN  = 3'd3,
    S_EW_YELLOW = 3'd4,
    S_ALLRED2   = 3'd5,
    S_WALK      = 3'd6
  } state_t;

  logic       r_s1, r_s2, r_s3;
  logic [1:0] r_fill;
  logic       r_armed;
  logic       r_p1, r_p2;
  logic       r_ped_pending;
  state_t     r_state;
  logic [5:0] r_timer;

  logic       w_tick;
  logic       w_enter_walk;
  state_t     w_next_state;
  logic [5:0] w_next_timer;

  function automatic logic [5:0] dur_of(input state_t s);
    case (s)
      S_NS_GREEN, S_EW_GREEN:   dur_of = L_GREEN;
      S_NS_YELLOW, S_EW_YELLOW: dur_of = L_YELLOW;
      S_WALK:                   dur_of = L_WALK;
      default:                  dur_of = L_ALLRED;
    endcase
  endfunction

  // s2 holds a real sample of the wave only once two edges have passed
  // since reset. Arming on a genuine low keeps a wave that is already high
  // at reset release from producing a tick.
  assign w_tick       = r_armed & r_s2 & ~r_s3;
  assign tick         = w_tick;
  assign seconds_left = r_timer;

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      r_s1          <= 1'b0;
      r_s2          <= 1'b0;
      r_s3          <= 1'b0;
      r_fill        <= 2'd0;
      r_armed       <= 1'b0;
      r_p1          <= 1'b0;
      r_p2          <= 1'b0;
      r_ped_pending <= 1'b0;
      r_state       <= S_ALLRED2;
      r_timer       <= L_ALLRED;
    end else begin
      r_s1 <= clk_1Hz;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
      if (r_fill != 2'd2) begin
        r_fill <= r_fill + 2'd1;
      end
      r_armed       <= r_armed | ((r_fill == 2'd2) & ~r_s2);
      r_p1          <= ped_req;
      r_p2          <= r_p1;
      // A request still present on the WALK-entry cycle must survive the clear.
      r_ped_pending <= r_p2 | (r_ped_pending & ~w_enter_walk);
      r_state       <= w_next_state;
      r_timer       <= w_next_timer;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_timer = r_timer;
    w_enter_walk = 1'b0;
    ns_light     = 3'b100;
    ew_light     = 3'b100;
    walk         = 1'b0;

    if (w_tick) begin
      if (r_timer == 6'd1) begin
        case (r_state)
          S_NS_GREEN:  w_next_state = S_NS_YELLOW;
          S_NS_YELLOW: w_next_state = S_ALLRED1;
          S_ALLRED1:   w_next_state = S_EW_GREEN;
          S_EW_GREEN:  w_next_state = S_EW_YELLOW;
          S_EW_YELLOW: w_next_state = S_ALLRED2;
          S_ALLRED2: begin
            if (r_ped_pending) begin
              w_next_state = S_WALK;
              w_enter_walk = 1'b1;
            end else begin
              w_next_state = S_NS_GREEN;
            end
          end
          S_WALK:      w_next_state = S_NS_GREEN;
          default:     w_next_state = S_ALLRED2;
        endcase
        w_next_timer = dur_of(w_next_state);
      end else begin
        w_next_timer = r_timer - 6'd1;
      end
    end

    case (r_state)
      S_NS_GREEN:  ns_light = 3'b001;
      S_NS_YELLOW: ns_light = 3'b010;
      S_EW_GREEN:  ew_light = 3'b001;
      S_EW_YELLOW: ew_light = 3'b010;
      S_WALK:      walk     = 1'b1;
      default: begin
        ns_light = 3'b100;
        ew_light = 3'b100;
      end
    endcase
  end

endmodule

// File: doc/traffic_light_ctrl.md
# traffic_light_ctrl

Two-road (north-south / east-west) traffic-light sequencer with a pedestrian phase. It consumes the `clk_1Hz` square wave produced by the 1 Hz divider, but never uses it as a clock. It synchronises the wave into the `clk_100MHz` domain, turns each rising edge into a single-cycle tick, and advances its phase timers on that tick. Outputs drive the board LEDs and a seconds-remaining display.

## Interface
- `GREEN_S`, 10: green duration in seconds, legal range 1..63.
- `YELLOW_S`, 3: yellow duration in seconds, 1..63.
- `ALLRED_S`, 1: all-red clearance duration in seconds, 1..63.
- `WALK_S`, 5: pedestrian walk duration in seconds, 1..63.
- `clk_100MHz`, in, 1: system clock.
- `reset`, in, 1: reset, asynchronous, active-high; clock `clk_100MHz`.
- `clk_1Hz`, in, 1: asynchronous 1 Hz square wave from the divider.
- `ped_req`, in, 1: asynchronous pedestrian button, level or pulse.
- `ns_light`, out, 3: {red, yellow, green} for north-south, one-hot.
- `ew_light`, out, 3: {red, yellow, green} for east-west, one-hot.
- `walk`, out, 1: pedestrian walk lamp.
- `seconds_left`, out, 6: ticks remaining in the current phase.
- `tick`, out, 1: one-cycle 1 Hz strobe, exported for the display scan.

## Operation
- **Synchroniser.**
  - `clk_1Hz` passes through three flops, s1→s2→s3, all reset to 0.
  - `armed` flag is reset to 0 and set on the first cycle s2==0.
  - `tick = armed & s2 & ~s3`. A wave that is already high at reset release produces no tick until its next genuine rising edge.
- **Pedestrian request.**
  - `ped_req` uses a two-flop synchroniser.
  - A sticky `ped_pending` sets on any synchronised high.
  - `ped_pending` clears on the cycle the state machine enters WALK.
  - If a synchronised request is high on that same cycle, the set wins and `ped_pending` stays 1.
- **States and lights.** Lights are decoded from the state register.
  - NS_GREEN: ns=001, ew=100.
  - NS_YELLOW: ns=010, ew=100.
  - ALLRED1: both 100.
  - EW_GREEN: ns=100, ew=001.
  - EW_YELLOW: ns=100, ew=010.
  - ALLRED2: both 100.
  - WALK: both 100, walk=1.
  - `walk` is 0 in every state except WALK.
- **Transitions.** Each state lasts exactly its duration in ticks.
  - NS_GREEN→NS_YELLOW→ALLRED1→EW_GREEN→EW_YELLOW→ALLRED2.
  - From ALLRED2: go to WALK if `ped_pending`==1 at the exiting tick, otherwise to NS_GREEN.
  - WALK→NS_GREEN.
- **Timer.** 6-bit `timer`, output as `seconds_left`.
  - On each tick: if timer==1, the state transitions and timer loads the next state's duration; otherwise timer decrements.
  - Timer never holds 0 and never wraps.
- **Duration clamping.** A duration parameter of 0 is treated as 1. The clamp is resolved at elaboration.
- **Reset values.**
  - state=ALLRED2, timer=ALLRED_S.
  - ns_light=100, ew_light=100, walk=0, seconds_left=ALLRED_S, tick=0.
  - ped_pending=0, armed=0, all synchroniser flops 0.
- **Reset mid-phase.** Any state returns immediately (asynchronously) to the reset values. A pending pedestrian request is discarded.

## Timing
- **Tick latency.** `clk_1Hz` is first sampled high at clock edge k (s1=1). s2 goes to 1 at edge k+1. `tick` is high for exactly one cycle, between edges k+1 and k+2. State, timer and light outputs update at edge k+2.
- **Input requirements.** `clk_1Hz` high and low times must each be ≥3 `clk_100MHz` cycles. Each rising edge gives exactly one tick.
- **Request latency.** `ped_req` must be high for ≥2 cycles to be guaranteed captured. `ped_pending` sets 2 edges after first sampling.
- **Full cycle length.**
  - Without a pedestrian: 2·GREEN_S + 2·YELLOW_S + 2·ALLRED_S ticks; 28 with defaults.
  - With a pedestrian: add WALK_S.
- **Output timing.** All outputs are glitch-free registered or state-decoded values, constant between ticks.

## Test plan
- **Reset and first tick.** Reset with `clk_1Hz` held high, release, keep it high for 50 cycles. Required: no tick; lights both 100, seconds_left=1. Then drop the wave low and raise it. Required: tick 2 edges after the raise is sampled; state becomes NS_GREEN with seconds_left=10.
- **Full cycle, no request.** Drive `clk_1Hz` with a 20-cycle period for 28 ticks. Required sequence of (ns, ew, seconds_left): 001/100 10..1, 010/100 3..1, 100/100 1, 100/001 10..1, 100/010 3..1, 100/100 1. Then back to NS_GREEN. `walk` stays 0 throughout.
- **Pedestrian request.** Pulse `ped_req` for 2 cycles during EW_GREEN. Required: after ALLRED2, WALK with walk=1 and both lights 100 for 5 ticks (seconds_left 5..1). Then NS_GREEN with seconds_left=10 and ped_pending=0.
- **Simultaneous request and clear.** Hold `ped_req` high across the WALK-entry edge. Required: ped_pending is still 1 after entry, and a second WALK occurs one full cycle later.
- **Reset mid-operation.** Assert reset during EW_YELLOW with seconds_left=2. Required: outputs are immediately 100/100, walk=0, seconds_left=1. A ped_pending that was set before reset is cleared.
- **Tick width.** Drive a `clk_1Hz` with 3-cycle high and 3-cycle low times. Required: exactly one single-cycle tick per rising edge; 10 edges give 10 ticks.
